// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// adder_pkg: shared types for the 12-bit prefix adder and its checker path
// Rev 1.0
// ============================================================================
package adder_pkg;

    localparam int ADD_WIDTH = 12;

    typedef logic [ADD_WIDTH:0]   sum_t;
    typedef logic [ADD_WIDTH-1:0] opnd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rec_state_t;

endpackage
`default_nettype wire

// File: rtl/adder_operand_recover_digit_sub.sv
`default_nettype none
// ============================================================================
// digit_sub: DIGIT-bit ripple-borrow subtractor slice, d = s - a - bin
// Rev 1.0
// ============================================================================
module digit_sub
    import adder_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] s,
    input  logic [DIGIT-1:0] a,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // One extra bit catches the borrow as the sign of the widened difference.
    logic [DIGIT:0] w_diff;

    assign w_diff = {1'b0, s} - {1'b0, a} - {{DIGIT{1'b0}}, bin};
    assign d      = w_diff[DIGIT-1:0];
    assign bout   = w_diff[DIGIT];

endmodule
`default_nettype wire

// File: rtl/adder_operand_recover.sv
`default_nettype none
// ============================================================================
// adder_operand_recover: recovers B = SUM - A, DIGIT bits per cycle
// Rev 1.0
// ============================================================================
module adder_operand_recover
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] a_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_op,
    output logic             err
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("adder_operand_recover: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    rec_state_t       r_state;
    rec_state_t       w_state_next;
    logic [WIDTH-1:0] r_s;
    logic             r_s_msb;
    logic [WIDTH-1:0] r_a;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT-1:0] w_d;
    logic             w_bout;

    digit_sub #(
        .DIGIT (DIGIT)
    ) u_digit_sub (
        .s    (r_s[DIGIT-1:0]),
        .a    (r_a[DIGIT-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_state_next = RUN;
            RUN:     if (r_cnt == LAST)  w_state_next = DONE;
            DONE:    if (out_ready)      w_state_next = IDLE;
            default:                     w_state_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s      <= '0;
            r_s_msb  <= 1'b0;
            r_a      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            b_op     <= '0;
            err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s      <= sum[WIDTH-1:0];
                        r_s_msb  <= sum[WIDTH];
                        r_a      <= a_op;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_s      <= r_s >> DIGIT;
                    r_a      <= r_a >> DIGIT;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CW'(1);
                    b_op     <= {w_d, b_op[WIDTH-1:DIGIT]};
                    // top = S[WIDTH] - borrow is nonzero (+1 overflow, -1 underflow)
                    // exactly when the two bits differ.
                    if (r_cnt == LAST) begin
                        err <= r_s_msb ^ w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_operand_recover.sv
`default_nettype none
// ============================================================================
// tb_adder_operand_recover: directed table, corner sequences, random scoreboard
// Rev 1.0
// ============================================================================
module tb_adder_operand_recover;

    parameter int DIGIT = 2;
    localparam int W     = 12;
    localparam int STEPS = W / DIGIT;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   sum;
    logic [W-1:0] a_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] b_op;
    logic         err;

    int applied;
    int miscompares;

    adder_operand_recover #(
        .WIDTH (W),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .a_op      (a_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_op      (b_op),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    typedef struct {
        logic [W:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, flag anything outside [0, 2**W-1].
    task automatic model(input logic [W:0] s, input logic [W-1:0] a,
                         output logic [W-1:0] b, output logic e);
        int          diff;
        logic [31:0] wrap;
        diff = int'(s) - int'(a);
        wrap = 32'(s) - 32'(a);
        b    = wrap[W-1:0];
        e    = (diff < 0) || (diff >= (1 << W));
    endtask

    task automatic run_job(input logic [W:0] s, input logic [W-1:0] a, input bit rand_ready,
                           output logic [W-1:0] b, output logic e, output int lat);
        int   n;
        logic held;
        @(negedge clk);
        sum      = s;
        a_op     = a;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
        b    = b_op;
        e    = err;
        held = 1'b1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        while (!out_ready) begin
            @(negedge clk);
            if (b_op !== b || err !== e || out_valid !== 1'b1) held = 1'b0;
            n++;
            out_ready = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        if (rand_ready) chk("hold_stable", 32'(held), 32'd1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t         tbl[8];
        logic [W-1:0] b, exp_b;
        logic         e, exp_e;
        int           lat, n;
        logic         seen;
        logic [W:0]   rs;
        logic [W-1:0] ra, rb;

        applied     = 0;
        miscompares = 0;

        tbl[0] = '{13'h0FFF, 12'h800, 12'h7FF, 1'b0};
        tbl[1] = '{13'h1FFE, 12'hFFF, 12'hFFF, 1'b0};
        tbl[2] = '{13'h1000, 12'h000, 12'h000, 1'b1};
        tbl[3] = '{13'h0005, 12'h006, 12'hFFF, 1'b1};
        tbl[4] = '{13'h0ABC, 12'hABC, 12'h000, 1'b0};
        tbl[5] = '{13'h1122, 12'h123, 12'hFFF, 1'b0};
        tbl[6] = '{13'h1FFF, 12'h000, 12'hFFF, 1'b1};
        tbl[7] = '{13'h0000, 12'hFFF, 12'h001, 1'b1};

        // Reset with a pending request
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        sum       = 13'h0FFF;
        a_op      = 12'h800;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_b_op", 32'(b_op), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_no_capture", 32'(in_ready), 32'd1);

        foreach (tbl[i]) begin
            run_job(tbl[i].s, tbl[i].a, 1'b0, b, e, lat);
            chk($sformatf("tbl%0d_b_op", i), 32'(b), 32'(tbl[i].b));
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(STEPS + 1));
            chk($sformatf("tbl%0d_idle", i), 32'(in_ready), 32'd1);
        end

        // Backpressure with a second request held throughout
        @(negedge clk);
        sum      = 13'h0010;
        a_op     = 12'h001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sum  = 13'h0020;
        a_op = 12'h005;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            chk("bp_b_op", 32'(b_op), 32'h00F);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_after_hs_ready", 32'(in_ready), 32'd1);
        chk("bp_after_hs_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_b_op", 32'(b_op), 32'h01B);
        chk("bp_second_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse in the middle of a job
        sum      = 13'h0FFF;
        a_op     = 12'h001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_b_op", 32'(b_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (STEPS + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        run_job(13'h0003, 12'h001, 1'b0, b, e, lat);
        chk("midrst_next_b_op", 32'(b), 32'h002);
        chk("midrst_next_err", 32'(e), 32'd0);

        // Random scoreboard, mostly legal sums plus arbitrary ones
        for (int j = 0; j < 3000; j++) begin
            ra = W'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                rb = W'($urandom);
                rs = (W + 1)'(ra) + (W + 1)'(rb);
            end else begin
                rs = (W + 1)'($urandom);
            end
            model(rs, ra, exp_b, exp_e);
            run_job(rs, ra, 1'b1, b, e, lat);
            chk($sformatf("rnd%0d_b_op s=%0h a=%0h", j, rs, ra), 32'(b), 32'(exp_b));
            chk($sformatf("rnd%0d_err s=%0h a=%0h", j, rs, ra), 32'(e), 32'(exp_e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
